// File: rtl/complex_acc_pkg.sv
// -----------------------------------------------------------------------------
// complex_acc_pkg
// Shared definitions for the complex accumulator:
//   - state_e      : integration FSM state encoding
//   - SAT_FULL_W   : working width for the saturation limit helpers
//   - sat_max_f()  : largest signed value representable in w bits
//   - sat_min_f()  : smallest signed value representable in w bits
// The limit helpers return SAT_FULL_W-bit values; callers width-cast the
// result down to their own data width.
// -----------------------------------------------------------------------------
package complex_acc_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,  // no integration open
    ST_ACC  = 1'b1   // integration open
  } state_e;

  localparam int SAT_FULL_W = 128;

  // 2^(w-1)-1, returned in SAT_FULL_W bits
  function automatic logic [SAT_FULL_W-1:0] sat_max_f(input int w);
    logic [SAT_FULL_W-1:0] one_s;
    one_s = 128'd1;
    return (one_s << (w - 1)) - 128'd1;
  endfunction

  // -2^(w-1); the low w bits of ~max are 1 followed by zeros
  function automatic logic [SAT_FULL_W-1:0] sat_min_f(input int w);
    return ~sat_max_f(w);
  endfunction

endpackage : complex_acc_pkg

// File: rtl/signed_sat_add.sv
// -----------------------------------------------------------------------------
// signed_sat_add
// Combinational signed adder with saturation to the W-bit signed range.
// Ports:
//   a, b : signed W-bit operands
//   sum  : a + b clamped to [-2^(W-1), 2^(W-1)-1]
//   sat  : high when the true sum fell outside the range and was clamped
// -----------------------------------------------------------------------------
module signed_sat_add
  import complex_acc_pkg::*;
#(
  parameter int W = 48
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  output logic signed [W-1:0] sum,
  output logic                sat
);

  localparam logic [W-1:0] SAT_MAX = W'(sat_max_f(W));
  localparam logic [W-1:0] SAT_MIN = W'(sat_min_f(W));

  logic [W:0] full_s;

  // One guard bit: the W+1-bit sum cannot wrap, and the two top bits
  // disagreeing means the result does not fit in W bits.
  always_comb begin
    full_s = {a[W-1], a} + {b[W-1], b};
    if (full_s[W] != full_s[W-1]) begin
      sat = 1'b1;
      sum = full_s[W] ? SAT_MIN : SAT_MAX;
    end else begin
      sat = 1'b0;
      sum = full_s[W-1:0];
    end
  end

endmodule : signed_sat_add

// File: rtl/complex_acc.sv
// -----------------------------------------------------------------------------
// complex_acc
// Integrates a stream of signed complex samples over acc_len valid samples,
// with saturating accumulation and a per-integration overflow flag.
// Ports:
//   clk, rst           : rising-edge clock, async active-high reset
//   din_re, din_im     : signed DIN_WIDTH sample, qualified by din_valid
//   acc_len            : samples per integration (0 behaves as 1), sampled
//                        when an integration opens
//   sync               : one-cycle restart; drops the open partial sum
//   dout_re, dout_im   : signed DOUT_WIDTH integrated sums, held between dumps
//   dout_valid         : one-cycle pulse, the cycle after the closing sample
//   ovf                : saturation happened in the integration presented
// -----------------------------------------------------------------------------
module complex_acc
  import complex_acc_pkg::*;
#(
  parameter int DIN_WIDTH  = 33,
  parameter int DOUT_WIDTH = 48,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic signed [DIN_WIDTH-1:0]  din_re,
  input  logic signed [DIN_WIDTH-1:0]  din_im,
  input  logic                         din_valid,
  input  logic        [LEN_WIDTH-1:0]  acc_len,
  input  logic                         sync,
  output logic signed [DOUT_WIDTH-1:0] dout_re,
  output logic signed [DOUT_WIDTH-1:0] dout_im,
  output logic                         dout_valid,
  output logic                         ovf
);

  // Registered state
  state_e                  state_q, state_d;
  logic [LEN_WIDTH-1:0]    count_q, count_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [DOUT_WIDTH-1:0]   acc_re_q, acc_re_d;
  logic [DOUT_WIDTH-1:0]   acc_im_q, acc_im_d;
  logic                    ovf_flag_q, ovf_flag_d;
  logic [DOUT_WIDTH-1:0]   dout_re_q, dout_re_d;
  logic [DOUT_WIDTH-1:0]   dout_im_q, dout_im_d;
  logic                    dout_valid_q, dout_valid_d;
  logic                    ovf_q, ovf_d;

  // Datapath
  logic                    open_s;
  logic [DOUT_WIDTH-1:0]   din_re_ext_s, din_im_ext_s;
  logic [DOUT_WIDTH-1:0]   add_a_re_s, add_a_im_s;
  logic [DOUT_WIDTH-1:0]   sum_re_s, sum_im_s;
  logic                    sat_re_s, sat_im_s;
  logic [LEN_WIDTH-1:0]    len_eff_s, count_next_s;
  logic                    flag_next_s;

  // A valid sample opens a new integration from IDLE, or restarts one when
  // sync accompanies it; opening adds the sample to zero so it loads as-is.
  always_comb begin
    open_s       = din_valid && ((state_q == ST_IDLE) || sync);
    din_re_ext_s = DOUT_WIDTH'(din_re);
    din_im_ext_s = DOUT_WIDTH'(din_im);
    if (open_s) begin
      add_a_re_s = '0;
      add_a_im_s = '0;
    end else begin
      add_a_re_s = acc_re_q;
      add_a_im_s = acc_im_q;
    end
  end

  signed_sat_add #(.W(DOUT_WIDTH)) u_add_re (
    .a   (add_a_re_s),
    .b   (din_re_ext_s),
    .sum (sum_re_s),
    .sat (sat_re_s)
  );

  signed_sat_add #(.W(DOUT_WIDTH)) u_add_im (
    .a   (add_a_im_s),
    .b   (din_im_ext_s),
    .sum (sum_im_s),
    .sat (sat_im_s)
  );

  // Integration length, sample count and sticky flag as they would stand
  // after accepting the current sample.
  always_comb begin
    if (open_s) begin
      len_eff_s    = (acc_len == {LEN_WIDTH{1'b0}}) ? LEN_WIDTH'(1) : acc_len;
      count_next_s = LEN_WIDTH'(1);
      flag_next_s  = sat_re_s | sat_im_s;
    end else begin
      len_eff_s    = len_q;
      count_next_s = count_q + LEN_WIDTH'(1);
      flag_next_s  = ovf_flag_q | sat_re_s | sat_im_s;
    end
  end

  // Next-state logic for the FSM, accumulators and output registers.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    len_d        = len_q;
    acc_re_d     = acc_re_q;
    acc_im_d     = acc_im_q;
    ovf_flag_d   = ovf_flag_q;
    dout_re_d    = dout_re_q;
    dout_im_d    = dout_im_q;
    dout_valid_d = 1'b0;
    ovf_d        = ovf_q;
    if (din_valid) begin
      acc_re_d = sum_re_s;
      acc_im_d = sum_im_s;
      len_d    = len_eff_s;
      if (count_next_s == len_eff_s) begin
        // Closing sample: dump the sum including this sample and go idle.
        state_d      = ST_IDLE;
        count_d      = '0;
        ovf_flag_d   = 1'b0;
        dout_re_d    = sum_re_s;
        dout_im_d    = sum_im_s;
        dout_valid_d = 1'b1;
        ovf_d        = flag_next_s;
      end else begin
        state_d    = ST_ACC;
        count_d    = count_next_s;
        ovf_flag_d = flag_next_s;
      end
    end else if (sync) begin
      // Restart without a sample: drop the partial sum silently.
      state_d    = ST_IDLE;
      count_d    = '0;
      ovf_flag_d = 1'b0;
    end else begin
      state_d = state_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      len_q        <= '0;
      acc_re_q     <= '0;
      acc_im_q     <= '0;
      ovf_flag_q   <= 1'b0;
      dout_re_q    <= '0;
      dout_im_q    <= '0;
      dout_valid_q <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      len_q        <= len_d;
      acc_re_q     <= acc_re_d;
      acc_im_q     <= acc_im_d;
      ovf_flag_q   <= ovf_flag_d;
      dout_re_q    <= dout_re_d;
      dout_im_q    <= dout_im_d;
      dout_valid_q <= dout_valid_d;
      ovf_q        <= ovf_d;
    end
  end

  assign dout_re    = dout_re_q;
  assign dout_im    = dout_im_q;
  assign dout_valid = dout_valid_q;
  assign ovf        = ovf_q;

endmodule : complex_acc

// File: doc/complex_acc.md
COMPLEX_ACC -- requirements
Module: complex_acc

Interface
REQ-001 SHALL have parameter DIN_WIDTH, default 33: signed width of din_re/din_im, matching the complex multiplier output (DIN1_WIDTH+DIN2_WIDTH+1).
REQ-002 SHALL have parameter DOUT_WIDTH, default 48: signed accumulator and output width; DOUT_WIDTH >= DIN_WIDTH.
REQ-003 SHALL have parameter LEN_WIDTH, default 16: width of acc_len.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have ports din_re and din_im, input, DIN_WIDTH each: signed complex sample from the upstream complex multiplier.
REQ-007 SHALL have port din_valid, input, 1: qualifies din_re/din_im; no backpressure.
REQ-008 SHALL have port acc_len, input, LEN_WIDTH: samples per integration, unsigned.
REQ-009 SHALL have port sync, input, 1: single-cycle restart pulse.
REQ-010 SHALL have ports dout_re and dout_im, output, DOUT_WIDTH each: signed integrated sums.
REQ-011 SHALL have port dout_valid, output, 1: one-cycle pulse per completed integration.
REQ-012 SHALL have port ovf, output, 1: saturation occurred in the integration now presented; valid with dout_valid.

Function
REQ-013 SHALL sign-extend din_re/din_im to DOUT_WIDTH and accumulate re and im independently.
REQ-014 SHALL implement a two-state FSM:
- IDLE: no integration open.
- ACC: integration open.
REQ-015 IDLE -> ACC on din_valid:
- accumulators load the sample.
- count := 1.
- len_q := acc_len, with acc_len = 0 treated as 1.
REQ-016 In ACC, each din_valid SHALL add the sample to the accumulators and increment count; cycles without din_valid leave all state unchanged.
REQ-017 When the accepted sample makes count equal len_q, the block SHALL close the integration:
- register the final sum (including that sample) into dout_re/dout_im.
- pulse dout_valid high for exactly one cycle, on the cycle after that sample's edge (latency 1).
- return to IDLE, so the next valid sample opens a new integration with no gap.
REQ-018 With len_q = 1, every valid sample SHALL produce dout_valid on the following cycle with dout equal to the sign-extended sample.
REQ-019 acc_len SHALL be sampled only at integration start; changes mid-integration SHALL NOT affect the open integration.
REQ-020 Every addition SHALL saturate to the signed DOUT_WIDTH range: max 2^(DOUT_WIDTH-1)-1, min -2^(DOUT_WIDTH-1). Any saturation SHALL set a per-integration sticky flag, cleared at integration start and presented on ovf with dout_valid.
REQ-021 sync high SHALL discard the open partial integration with no output. If din_valid is high in the same cycle, that sample SHALL start a new integration per REQ-015; otherwise the FSM goes to IDLE.
REQ-022 sync in the same cycle as a closing sample SHALL take priority: no dout_valid, and the sample starts a new integration.
REQ-023 dout_re, dout_im and ovf SHALL hold their last values between dout_valid pulses.

Reset
REQ-024 rst SHALL asynchronously force: FSM to IDLE; count, len_q, accumulators and ovf flag to 0; dout_re, dout_im, dout_valid and ovf to 0.
REQ-025 Reset asserted mid-integration SHALL discard the partial sum; after release, the first din_valid opens a fresh integration.

Structure
REQ-026 FSM state encodings and the saturation limit constants SHALL live in a shared include/package (complex_acc_pkg).
REQ-027 Saturating signed addition SHALL be a sub-module, signed_sat_add (inputs a, b; outputs sum, sat), instantiated once for re and once for im.
REQ-028 The block SHALL be pipelined so that the adder plus saturation logic is the only logic between registers.

Verification
REQ-029 acc_len=4, din=(1,-1) valid every cycle -> dout=(4,-4), dout_valid one cycle after each 4th sample, repeating every 4 cycles with no gap.
REQ-030 acc_len=3, din_valid with gaps, samples (5,0),(−2,7),(10,−3) -> single dout=(13,4), ovf=0.
REQ-031 acc_len=0 and acc_len=1, din=(−7,9) -> dout=(−7,9) after every sample.
REQ-032 DOUT_WIDTH=34, DIN_WIDTH=33, acc_len=4, din=(2^32−1, −2^32) -> dout=(2^33−1, −2^33), ovf=1.
REQ-033 acc_len=8: sync after 5 samples -> no output; the next 8 samples give a correct sum. rst after 3 samples -> all outputs 0 and a fresh integration follows.
REQ-034 acc_len changed from 4 to 2 mid-integration -> current dump uses 4, next uses 2.
